// File: rtl/quiz_pkg.sv
// rtl/quiz_pkg.sv - shared encodings for the quiz round controller
package quiz_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ASK   = 3'd1;
  localparam logic [2:0] ST_JUDGE = 3'd2;
  localparam logic [2:0] ST_SHOW  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_LEFT  = 2'b01;
  localparam logic [1:0] RES_RIGHT = 2'b10;

  localparam int SCORE_W = 5;
  localparam logic [SCORE_W-1:0] SCORE_FULL = '1;

  // Shifting in a one saturates naturally once the thermometer is full.
  function automatic logic [SCORE_W-1:0] score_bump(input logic [SCORE_W-1:0] s);
    return {s[SCORE_W-2:0], 1'b1};
  endfunction

endpackage

// File: rtl/buzz_arbiter.sv
// rtl/buzz_arbiter.sv - joystick press detect, lockouts and tie priority
module buzz_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear_lock,
  input  logic       lock_left,
  input  logic       lock_right,
  input  logic [8:0] joy_left,
  input  logic [8:0] joy_right,
  output logic       grant_left,
  output logic       grant_right,
  output logic [8:0] grant_vec,
  output logic       locked_left,
  output logic       locked_right
);

  logic [8:0] joy_left_r;
  logic [8:0] joy_right_r;
  logic       prio_right;
  logic       elig_left;
  logic       elig_right;

  // A press is the first cycle any button is down after all were released.
  assign elig_left  = enable && !locked_left  && (joy_left  != '0) && (joy_left_r  == '0);
  assign elig_right = enable && !locked_right && (joy_right != '0) && (joy_right_r == '0);

  assign grant_left  = elig_left  && (!elig_right || !prio_right);
  assign grant_right = elig_right && (!elig_left  ||  prio_right);
  assign grant_vec   = grant_right ? joy_right : joy_left;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      joy_left_r   <= '0;
      joy_right_r  <= '0;
      prio_right   <= 1'b0;
      locked_left  <= 1'b0;
      locked_right <= 1'b0;
    end else begin
      joy_left_r  <= joy_left;
      joy_right_r <= joy_right;
      if (elig_left && elig_right) prio_right <= !prio_right;
      if (clear_lock) begin
        locked_left  <= 1'b0;
        locked_right <= 1'b0;
      end else begin
        if (lock_left)  locked_left  <= 1'b1;
        if (lock_right) locked_right <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/quiz_round_ctrl.sv
// rtl/quiz_round_ctrl.sv - quiz round sequencer, judge and score keeper
module quiz_round_ctrl #(
  parameter int NUM_Q       = 9,
  parameter int WIN_SCORE   = 5,
  parameter int TIMEOUT_CYC = 1000,
  parameter int HOLD_CYC    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       selector,
  input  logic [8:0] joy_left,
  input  logic [8:0] joy_right,
  input  logic [8:0] answer_key,
  output logic [3:0] q_index,
  output logic       q_bank,
  output logic       q_valid,
  output logic [4:0] score_left,
  output logic [4:0] score_right,
  output logic [1:0] result,
  output logic [1:0] winner,
  output logic       busy
);
  import quiz_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [SCORE_W-1:0] WIN_MASK = SCORE_FULL >> (SCORE_W - WIN_SCORE);

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [8:0]    cap_vec;
  logic          cap_left;
  logic          grant_left, grant_right, locked_left, locked_right;
  logic [8:0]    grant_vec;
  logic          start_ok, show_end, correct, lock_left, lock_right, clear_lock, other_locked;

  assign start_ok     = start && (state == ST_IDLE || state == ST_DONE);
  assign show_end     = (state == ST_SHOW) && (timer == TW'(HOLD_CYC - 1));
  assign correct      = (cap_vec == answer_key);
  assign lock_left    = (state == ST_JUDGE) && !correct &&  cap_left;
  assign lock_right   = (state == ST_JUDGE) && !correct && !cap_left;
  assign other_locked = cap_left ? locked_right : locked_left;
  assign clear_lock   = start_ok || show_end;
  assign q_valid      = (state == ST_ASK) || (state == ST_JUDGE);
  assign busy         = !(state == ST_IDLE || state == ST_DONE);

  buzz_arbiter u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (state == ST_ASK),
    .clear_lock   (clear_lock),
    .lock_left    (lock_left),
    .lock_right   (lock_right),
    .joy_left     (joy_left),
    .joy_right    (joy_right),
    .grant_left   (grant_left),
    .grant_right  (grant_right),
    .grant_vec    (grant_vec),
    .locked_left  (locked_left),
    .locked_right (locked_right)
  );

  // The timer counts press-free ASK cycles, then doubles as the SHOW hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      timer       <= '0;
      cap_vec     <= '0;
      cap_left    <= 1'b0;
      q_index     <= '0;
      q_bank      <= 1'b0;
      score_left  <= '0;
      score_right <= '0;
      result      <= RES_NONE;
      winner      <= RES_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            q_bank      <= selector;
            q_index     <= '0;
            score_left  <= '0;
            score_right <= '0;
            result      <= RES_NONE;
            winner      <= RES_NONE;
            timer       <= '0;
            state       <= ST_ASK;
          end
        end
        ST_ASK: begin
          if (grant_left || grant_right) begin
            cap_vec  <= grant_vec;
            cap_left <= grant_left;
            state    <= ST_JUDGE;
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            result <= RES_NONE;
            timer  <= '0;
            state  <= ST_SHOW;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_JUDGE: begin
          if (correct) begin
            if (cap_left) begin
              score_left <= score_bump(score_left);
              result     <= RES_LEFT;
            end else begin
              score_right <= score_bump(score_right);
              result      <= RES_RIGHT;
            end
            timer <= '0;
            state <= ST_SHOW;
          end else if (!other_locked) begin
            state <= ST_ASK;
          end else begin
            result <= RES_NONE;
            timer  <= '0;
            state  <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (show_end) begin
            timer <= '0;
            if (score_left == WIN_MASK) begin
              winner <= RES_LEFT;
              state  <= ST_DONE;
            end else if (score_right == WIN_MASK) begin
              winner <= RES_RIGHT;
              state  <= ST_DONE;
            end else begin
              q_index <= (q_index == 4'(NUM_Q - 1)) ? 4'd0 : q_index + 4'd1;
              state   <= ST_ASK;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb/tb_quiz_round_ctrl.sv - randomized scoreboard bench for quiz_round_ctrl
module tb_quiz_round_ctrl;

  localparam int NUM_Q   = 9;
  localparam int WIN     = 5;
  localparam int TO      = 1000;
  localparam int HOLD    = 4;
  localparam int NCYC    = 20000;

  logic       clk = 1'b0;
  logic       rst_n, start, selector;
  logic [8:0] joy_left, joy_right, answer_key;
  logic [3:0] q_index;
  logic       q_bank, q_valid, busy;
  logic [4:0] score_left, score_right;
  logic [1:0] result, winner;

  always #5 clk = ~clk;

  quiz_round_ctrl #(.NUM_Q(NUM_Q), .WIN_SCORE(WIN), .TIMEOUT_CYC(TO), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .selector(selector),
    .joy_left(joy_left), .joy_right(joy_right), .answer_key(answer_key),
    .q_index(q_index), .q_bank(q_bank), .q_valid(q_valid),
    .score_left(score_left), .score_right(score_right),
    .result(result), .winner(winner), .busy(busy)
  );

  typedef struct packed {
    logic [3:0] q;
    logic       bank;
    logic       qv;
    logic [4:0] sl;
    logic [4:0] sr;
    logic [1:0] res;
    logic [1:0] win;
    logic       busy;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: game-level view with integer points and countdowns.
  bit         m_run, m_judge;
  int         m_show, m_wait, m_q, m_bank, m_res, m_win, m_prio, m_cap_p;
  int         m_pts[2];
  bit         m_lock[2];
  logic [8:0] m_prev[2];
  logic [8:0] m_cap_v;

  function automatic logic [8:0] rom(input int b, input int q);
    logic [8:0] one = 9'd1;
    return one << ((q * 2 + b * 5 + 3) % 9);
  endfunction

  function automatic logic [4:0] therm(input int pts);
    logic [4:0] t = '0;
    for (int i = 0; i < pts; i++) t[i] = 1'b1;
    return t;
  endfunction

  task automatic model_reset();
    m_run = 0; m_judge = 0; m_show = 0; m_wait = 0; m_q = 0; m_bank = 0;
    m_res = 0; m_win = 0; m_prio = 0; m_cap_p = 0; m_cap_v = '0;
    m_pts[0] = 0; m_pts[1] = 0; m_lock[0] = 0; m_lock[1] = 0;
    m_prev[0] = '0; m_prev[1] = '0;
  endtask

  task automatic model_step(input logic r, input logic st, input logic sel,
                            input logic [8:0] jl, input logic [8:0] jr, input logic [8:0] key);
    bit el[2];
    int p;
    if (!r) begin
      model_reset();
      return;
    end
    el[0] = (jl != 0) && (m_prev[0] == 0) && !m_lock[0];
    el[1] = (jr != 0) && (m_prev[1] == 0) && !m_lock[1];
    if (!m_run) begin
      if (st) begin
        m_run = 1; m_bank = int'(sel); m_q = 0; m_pts[0] = 0; m_pts[1] = 0;
        m_res = 0; m_win = 0; m_wait = 0; m_lock[0] = 0; m_lock[1] = 0;
      end
    end else if (m_show > 0) begin
      m_show--;
      if (m_show == 0) begin
        if (m_pts[0] == WIN) begin m_win = 1; m_run = 0; end
        else if (m_pts[1] == WIN) begin m_win = 2; m_run = 0; end
        else begin
          m_q = (m_q + 1) % NUM_Q; m_wait = 0; m_lock[0] = 0; m_lock[1] = 0;
        end
      end
    end else if (m_judge) begin
      m_judge = 0;
      if (m_cap_v == key) begin
        if (m_pts[m_cap_p] < WIN) m_pts[m_cap_p]++;
        m_res = m_cap_p + 1;
        m_show = HOLD;
      end else begin
        m_lock[m_cap_p] = 1;
        if (m_lock[1 - m_cap_p]) begin m_res = 0; m_show = HOLD; end
      end
    end else begin
      p = -1;
      if (el[0] && el[1]) begin p = m_prio; m_prio = 1 - m_prio; end
      else if (el[0]) p = 0;
      else if (el[1]) p = 1;
      if (p >= 0) begin
        m_judge = 1; m_cap_p = p; m_cap_v = (p == 0) ? jl : jr;
      end else begin
        m_wait++;
        if (m_wait == TO) begin m_res = 0; m_show = HOLD; end
      end
    end
    m_prev[0] = jl;
    m_prev[1] = jr;
  endtask

  function automatic snap_t model_out();
    snap_t s;
    s.q    = 4'(m_q);
    s.bank = 1'(m_bank);
    s.qv   = m_run && (m_show == 0);
    s.sl   = therm(m_pts[0]);
    s.sr   = therm(m_pts[1]);
    s.res  = 2'(m_res);
    s.win  = 2'(m_win);
    s.busy = m_run;
    return s;
  endfunction

  function automatic logic [8:0] pick(input logic [8:0] prev, input logic [8:0] key);
    int r = $urandom_range(0, 99);
    logic [8:0] one = 9'd1;
    if (r < 45) return '0;
    if (r < 60) return prev;
    if (r < 80) return key;
    if (r < 92) return one << $urandom_range(0, 8);
    return 9'($urandom());
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected snapshot is consumed per cycle, away from the clock edge.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL queue_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        e = exp_q.pop_front();
        chk("q_index",     9'(q_index),     9'(e.q));
        chk("q_bank",      9'(q_bank),      9'(e.bank));
        chk("q_valid",     9'(q_valid),     9'(e.qv));
        chk("score_left",  9'(score_left),  9'(e.sl));
        chk("score_right", 9'(score_right), 9'(e.sr));
        chk("result",      9'(result),      9'(e.res));
        chk("winner",      9'(winner),      9'(e.win));
        chk("busy",        9'(busy),        9'(e.busy));
      end
    end
  end

  initial begin
    logic       n_rst, n_start, n_sel;
    logic [8:0] n_jl, n_jr, key;
    bit         quiet;
    rst_n = 1'b0; start = 1'b0; selector = 1'b0;
    joy_left = '0; joy_right = '0; answer_key = rom(0, 0);
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_step(rst_n, start, selector, joy_left, joy_right, answer_key);
      key   = rom(m_bank, m_q);
      quiet = (cyc >= 6000) && (cyc < 9500);
      if (cyc < 3)         n_rst = 1'b0;
      else if (!rst_n)     n_rst = 1'b1;
      else                 n_rst = ($urandom_range(0, 1499) != 0);
      n_start = ($urandom_range(0, 29) == 0);
      n_sel   = 1'($urandom_range(0, 1));
      n_jl    = quiet ? 9'd0 : pick(joy_left, key);
      n_jr    = quiet ? 9'd0 : pick(joy_right, key);
      if (!n_rst) model_reset();
      exp_q.push_back(model_out());
      #2;
      rst_n = n_rst; start = n_start; selector = n_sel;
      joy_left = n_jl; joy_right = n_jr;
      answer_key = rom(m_bank, m_q);
    end
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
